// File: rtl/c_pingpong_drain_buf.sv
// c_pingpong_drain_buf
//   Multi-bank C-tile result buffer behind the output-stationary systolic
//   array. One bank at a time captures per-cell result strobes (FILL); full
//   banks are handed to a valid/ready stream drain (row- or column-major)
//   while the next tile fills another bank. Any bank can be read by the CPU
//   with a registered 1-cycle read.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      synchronous soft clear of control state (not storage)
//   tile_start / start_ready   claim the next round-robin bank for a new tile
//   c_out_flat / c_valid_flat  per-cell result data and write strobes
//   tile_done                  1-cycle pulse when the filling bank is complete
//   drain_mode                 0 = row-major, 1 = column-major (latched at drain start)
//   out_valid/out_ready        drain stream handshake
//   out_data/out_row/out_col   drained element and its coordinates
//   out_bank / out_last        bank being drained, final element marker
//   rd_en/rd_bank/rd_row/rd_col  CPU read request and address
//   rd_data / rd_valid         registered CPU read data, valid one cycle after rd_en
//   banks_free / busy          number of FREE banks, any bank in use
//   err_start_drop             sticky: tile_start ignored because not ready
//   err_orphan                 sticky: cell strobes seen with no bank filling
module c_pingpong_drain_buf #(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int NBANK  = 2,
  parameter int BANK_W = (NBANK <= 1) ? 1 : $clog2(NBANK),
  parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W  = (N <= 1) ? 1 : $clog2(N),
  parameter int FREE_W = $clog2(NBANK + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  tile_start,
  output logic                  start_ready,
  input  logic [M*N*DATA_W-1:0] c_out_flat,
  input  logic [M*N-1:0]        c_valid_flat,
  output logic                  tile_done,
  input  logic                  drain_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col,
  output logic [BANK_W-1:0]     out_bank,
  output logic                  out_last,
  input  logic                  rd_en,
  input  logic [BANK_W-1:0]     rd_bank,
  input  logic [ROW_W-1:0]      rd_row,
  input  logic [COL_W-1:0]      rd_col,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [FREE_W-1:0]     banks_free,
  output logic                  busy,
  output logic                  err_start_drop,
  output logic                  err_orphan
);

  localparam int CELLS  = M * N;
  localparam int CELL_W = (CELLS <= 1) ? 1 : $clog2(CELLS);

  typedef enum logic [1:0] {
    S_FREE,
    S_FILL,
    S_READY,
    S_DRAIN
  } bank_state_e;

  bank_state_e         state [NBANK];
  logic [DATA_W-1:0]   mem   [NBANK][CELLS];

  logic [BANK_W-1:0]   wp;
  logic [BANK_W-1:0]   dp;
  logic [BANK_W-1:0]   wp_inc;
  logic [BANK_W-1:0]   dp_inc;
  logic [CELLS-1:0]    mask;
  logic [CELLS-1:0]    mask_next;
  logic [ROW_W-1:0]    row_cnt;
  logic [COL_W-1:0]    col_cnt;
  logic                mode_q;

  logic                any_fill;
  logic                fill_active;
  logic                drain_active;
  logic                last_row;
  logic                last_col;
  logic [FREE_W-1:0]   free_cnt;
  logic [CELL_W-1:0]   out_idx;
  logic [CELL_W-1:0]   rd_idx;
  logic                rd_in_range;
  logic [DATA_W-1:0]   rd_word;

  // Bank occupancy summary.
  always_comb begin
    any_fill = 1'b0;
    free_cnt = '0;
    for (int unsigned i = 0; i < NBANK; i++) begin
      if (state[i] == S_FILL) any_fill = 1'b1;
      if (state[i] == S_FREE) free_cnt = free_cnt + FREE_W'(1);
    end
  end

  // Only bank[wp] can ever be filling and only bank[dp] draining, since the
  // pointers advance only when their bank leaves FILL / DRAIN.
  always_comb begin
    fill_active  = (state[wp] == S_FILL);
    drain_active = (state[dp] == S_DRAIN);
    mask_next    = mask | c_valid_flat;
    wp_inc       = (wp == BANK_W'(NBANK - 1)) ? '0 : wp + BANK_W'(1);
    dp_inc       = (dp == BANK_W'(NBANK - 1)) ? '0 : dp + BANK_W'(1);
    last_row     = (row_cnt == ROW_W'(M - 1));
    last_col     = (col_cnt == COL_W'(N - 1));
    out_idx      = CELL_W'(row_cnt) * CELL_W'(N) + CELL_W'(col_cnt);
    rd_idx       = CELL_W'(rd_row) * CELL_W'(N) + CELL_W'(rd_col);
    rd_in_range  = (int'(rd_bank) < NBANK) && (int'(rd_row) < M) && (int'(rd_col) < N);
    rd_word      = rd_in_range ? mem[rd_bank][rd_idx] : '0;
  end

  assign start_ready = (state[wp] == S_FREE) && !any_fill;
  assign out_valid   = drain_active;
  assign out_data    = mem[dp][out_idx];
  assign out_row     = row_cnt;
  assign out_col     = col_cnt;
  assign out_bank    = dp;
  assign out_last    = drain_active && last_row && last_col;
  assign banks_free  = free_cnt;
  assign busy        = (free_cnt != FREE_W'(NBANK));

  // Tile storage: no reset, written only while a bank is filling. A cell
  // strobed while its bank is already complete still overwrites (last wins).
  always_ff @(posedge clk) begin
    if (rst_n && !flush && fill_active) begin
      for (int unsigned i = 0; i < CELLS; i++) begin
        if (c_valid_flat[i]) mem[wp][i] <= c_out_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  // Bank lifecycle, pointers, drain counters, CPU read port and error flags.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int unsigned i = 0; i < NBANK; i++) state[i] <= S_FREE;
      wp             <= '0;
      dp             <= '0;
      mask           <= '0;
      row_cnt        <= '0;
      col_cnt        <= '0;
      mode_q         <= 1'b0;
      tile_done      <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      err_start_drop <= 1'b0;
      err_orphan     <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      rd_valid  <= rd_en;
      if (rd_en) rd_data <= rd_word;

      // Fill side. A start cannot coincide with an active fill because
      // start_ready requires no bank in FILL.
      if (tile_start) begin
        if (start_ready) begin
          state[wp] <= S_FILL;
          mask      <= '0;
        end else begin
          err_start_drop <= 1'b1;
        end
      end

      // Completion is detected on the write edge (tile_done), and the bank
      // is handed over on the following edge once the mask reads full.
      if (fill_active) begin
        mask <= mask_next;
        if (&mask) begin
          state[wp] <= S_READY;
          wp        <= wp_inc;
        end else if (&mask_next) begin
          tile_done <= 1'b1;
        end
      end

      if ((|c_valid_flat) && !any_fill) err_orphan <= 1'b1;

      // Drain side: touches only bank[dp], which is never the filling bank.
      if (state[dp] == S_READY) begin
        state[dp] <= S_DRAIN;
        mode_q    <= drain_mode;
        row_cnt   <= '0;
        col_cnt   <= '0;
      end else if (drain_active && out_ready) begin
        if (last_row && last_col) begin
          state[dp] <= S_FREE;
          dp        <= dp_inc;
          row_cnt   <= '0;
          col_cnt   <= '0;
        end else if (!mode_q) begin
          if (last_col) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + ROW_W'(1);
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
          end
        end else begin
          if (last_row) begin
            row_cnt <= '0;
            col_cnt <= col_cnt + COL_W'(1);
          end else begin
            row_cnt <= row_cnt + ROW_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_c_pingpong_drain_buf.sv
// tb_c_pingpong_drain_buf
//   Directed sequence with randomized tile data and handshake stalls for the
//   default 8x8, 32-bit, 2-bank buffer. A reference memory per bank records
//   every cell write; completed tiles are expanded into the expected drain
//   beat order, which the observed stream is compared against.
module tb_c_pingpong_drain_buf;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          tile_start = 1'b0;
  logic          start_ready;
  logic [2047:0] c_out_flat = '0;
  logic [63:0]   c_valid_flat = '0;
  logic          tile_done;
  logic          drain_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [2:0]    out_row;
  logic [2:0]    out_col;
  logic [0:0]    out_bank;
  logic          out_last;
  logic          rd_en = 1'b0;
  logic [0:0]    rd_bank = '0;
  logic [2:0]    rd_row = '0;
  logic [2:0]    rd_col = '0;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [1:0]    banks_free;
  logic          busy;
  logic          err_start_drop;
  logic          err_orphan;

  c_pingpong_drain_buf #(
    .M(8), .N(8), .DATA_W(32), .NBANK(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .tile_start(tile_start), .start_ready(start_ready),
    .c_out_flat(c_out_flat), .c_valid_flat(c_valid_flat),
    .tile_done(tile_done), .drain_mode(drain_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_bank(out_bank), .out_last(out_last),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .banks_free(banks_free), .busy(busy),
    .err_start_drop(err_start_drop), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  r;
    logic [2:0]  c;
    logic        b;
    logic        l;
  } beat_t;

  logic [31:0] mdl [2][64];
  beat_t       exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_tile();
    chk("start_ready_before_start", start_ready, 1);
    tile_start = 1'b1;
    tick();
    tile_start = 1'b0;
  endtask

  // Record strobed cells into the reference bank, then clock them in.
  task automatic write_cycle(input int bank);
    for (int i = 0; i < 64; i++)
      if (c_valid_flat[i]) mdl[bank][i] = c_out_flat[i*32 +: 32];
    tick();
    c_valid_flat = '0;
  endtask

  // kind 0: cell(r,c) = r*8+c; kind 1: random data. All cells in one cycle.
  task automatic fill_all(input int bank, input int kind);
    for (int i = 0; i < 64; i++)
      c_out_flat[i*32 +: 32] = (kind == 0) ? 32'(i) : $urandom;
    c_valid_flat = '1;
    write_cycle(bank);
  endtask

  // Expected stream of one tile: the outer index walks rows (row-major) or
  // columns (col-major), the last beat is the one at (7,7).
  task automatic push_tile(input int bank, input bit cm);
    beat_t bt;
    int r;
    int c;
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 8; i++) begin
        r = cm ? i : o;
        c = cm ? o : i;
        bt.d = mdl[bank][r*8 + c];
        bt.r = 3'(r);
        bt.c = 3'(c);
        bt.b = 1'(bank);
        bt.l = (o == 7) && (i == 7);
        exp_q.push_back(bt);
      end
    end
  endtask

  // pat 0: always ready; 1: ready on every third cycle; 2: random ready.
  task automatic drain(input int n, input int pat);
    int    got;
    int    budget;
    beat_t act;
    got = 0;
    budget = 0;
    while (got < n && budget < n * 8 + 64) begin
      case (pat)
        0:       out_ready = 1'b1;
        1:       out_ready = (budget % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          act = {out_data, out_row, out_col, out_bank, out_last};
          chk("drain_beat", act, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      tick();
      budget++;
    end
    out_ready = 1'b0;
    chk("drain_count", got, n);
  endtask

  task automatic cpu_read(input int bank, input int r, input int c);
    rd_en   = 1'b1;
    rd_bank = 1'(bank);
    rd_row  = 3'(r);
    rd_col  = 3'(c);
    tick();
    rd_en   = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_start_ready", start_ready, 1);
    chk("rst_banks_free", banks_free, 2);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tile_done", tile_done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_errors", {err_start_drop, err_orphan}, 0);

    // Tile 1: pattern, single-cycle write, row-major, latency checks (bank0)
    drain_mode = 1'b0;
    start_tile();
    chk("fill_start_ready", start_ready, 0);
    fill_all(0, 0);
    push_tile(0, 0);
    chk("t1_tile_done", tile_done, 1);
    chk("t1_out_valid_early", out_valid, 0);
    tick();
    chk("t1_tile_done_pulse", tile_done, 0);
    chk("t1_out_valid_ready", out_valid, 0);
    chk("t1_banks_free_ready", banks_free, 1);
    tick();
    chk("t1_out_valid", out_valid, 1);
    drain(64, 0);
    chk("t1_after_valid", out_valid, 0);
    chk("t1_banks_free", banks_free, 2);
    chk("t1_busy", busy, 0);

    // Tile 2: same pattern, col-major (bank1)
    drain_mode = 1'b1;
    start_tile();
    fill_all(1, 0);
    push_tile(1, 1);
    tick();
    tick();
    drain(64, 0);
    chk("t2_banks_free", banks_free, 2);

    // Tile 3: random data with a same-cycle CPU read of a cell being written
    // (old value expected), then drained under periodic stalls (bank0)
    mode = 1'($urandom_range(0, 1));
    drain_mode = mode;
    start_tile();
    for (int i = 0; i < 64; i++) c_out_flat[i*32 +: 32] = $urandom;
    c_valid_flat = '1;
    rd_en = 1'b1; rd_bank = 1'b0; rd_row = 3'd2; rd_col = 3'd3;
    write_cycle(0);
    rd_en = 1'b0;
    chk("t3_rd_valid", rd_valid, 1);
    chk("t3_rd_old_value", rd_data, 19);
    push_tile(0, mode);
    tick();
    chk("t3_rd_valid_pulse", rd_valid, 0);
    drain(64, 1);
    cpu_read(0, 2, 3);
    chk("t3_rd_new_value", rd_data, mdl[0][19]);

    // Tile 4: two banks full, third start dropped, ordered drain
    do_reset();
    chk("t4_rst_errors", {err_start_drop, err_orphan}, 0);
    drain_mode = 1'b0;
    out_ready = 1'b0;
    start_tile();
    fill_all(0, 1);
    push_tile(0, 0);
    tick();
    tick();
    tick();
    start_tile();
    fill_all(1, 1);
    push_tile(1, 0);
    tick();
    tick();
    chk("t4_start_ready", start_ready, 0);
    tile_start = 1'b1;
    tick();
    tile_start = 1'b0;
    chk("t4_err_start_drop", err_start_drop, 1);
    chk("t4_start_ready_after", start_ready, 0);
    chk("t4_banks_free", banks_free, 0);
    chk("t4_busy", busy, 1);
    drain(128, 0);
    chk("t4_banks_free_end", banks_free, 2);

    // Tile 5: diagonal skew plus a late rewrite of cell (0,0) (bank0)
    mode = 1'($urandom_range(0, 1));
    drain_mode = mode;
    start_tile();
    for (int cyc = 0; cyc < 15; cyc++) begin
      c_valid_flat = '0;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          if (r + c == cyc) begin
            c_valid_flat[r*8 + c] = 1'b1;
            c_out_flat[(r*8 + c)*32 +: 32] = $urandom;
          end
        end
      end
      if (cyc == 3) begin
        c_valid_flat[0] = 1'b1;
        c_out_flat[31:0] = 32'hDEAD;
      end
      chk("t5_no_early_done", tile_done, 0);
      write_cycle(0);
    end
    chk("t5_tile_done", tile_done, 1);
    push_tile(0, mode);
    tick();
    tick();
    drain(64, 2);

    // Strobe with no filling bank: flagged and storage untouched
    chk("orphan_clear", err_orphan, 0);
    c_valid_flat[5] = 1'b1;
    c_out_flat[5*32 +: 32] = 32'h1234_5678;
    tick();
    c_valid_flat = '0;
    chk("orphan_set", err_orphan, 1);
    cpu_read(0, 0, 0);
    chk("t5_rd_dead", rd_data, 32'hDEAD);
    cpu_read(0, 0, 5);
    chk("orphan_no_write", rd_data, mdl[0][5]);

    // Flush during a partial fill (bank1): tile abandoned
    start_tile();
    for (int i = 0; i < 8; i++) c_out_flat[i*32 +: 32] = $urandom;
    c_valid_flat = 64'hFF;
    write_cycle(1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_start_ready", start_ready, 1);
    chk("flush_banks_free", banks_free, 2);
    chk("flush_busy", busy, 0);
    chk("flush_errors", {err_start_drop, err_orphan}, 0);
    tick();
    chk("flush_no_done", tile_done, 0);
    chk("flush_out_valid", out_valid, 0);

    // Tile 6: reset after ten drained beats, then CPU read of bank0
    drain_mode = 1'b0;
    start_tile();
    fill_all(0, 0);
    push_tile(0, 0);
    tick();
    tick();
    drain(10, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_start_ready", start_ready, 1);
    chk("t6_banks_free", banks_free, 2);
    chk("t6_busy", busy, 0);
    chk("t6_errors", {err_start_drop, err_orphan}, 0);
    chk("t6_rd_data_rst", rd_data, 0);
    tick();
    chk("t6_no_done", tile_done, 0);
    cpu_read(0, 2, 3);
    chk("t6_rd_valid", rd_valid, 1);
    chk("t6_rd_data", rd_data, 19);
    tick();
    chk("t6_rd_valid_pulse", rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
